// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM state type and default parameter values for cam_capture_ctrl.
package cam_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} cam_state_t;
    localparam int BYTES_PER_PIX_DEF = 2;
    localparam int CNT_W_DEF = 12;
    localparam int FRM_W_DEF = 16;
endpackage

// File: rtl/cam_byte_packer.sv
// cam_byte_packer: shifts camera bytes into a pixel word (first byte in MSBs) and tracks byte phase.
module cam_byte_packer import cam_pkg::*; #(
    parameter int BYTES_PER_PIX = BYTES_PER_PIX_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_en,
    input  logic [7:0]                 i_byte,
    output logic                       o_last,
    output logic [8*BYTES_PER_PIX-1:0] o_word
);
    localparam int PW = 8 * BYTES_PER_PIX;
    logic [1:0]    r_phase;
    logic [PW-1:0] r_sh;
    assign o_last = i_en && (r_phase == 2'(BYTES_PER_PIX - 1));
    assign o_word = (r_sh << 8) | PW'(i_byte);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_sh    <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
            r_sh    <= '0;
        end else if (i_en) begin
            r_phase <= o_last ? 2'd0 : r_phase + 2'd1;
            r_sh    <= o_word;
        end
    end
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: camera frame capture FSM with byte packing, counters and backpressure drop.
// Optional CAM_TEST_PATTERN_EN adds a test_pattern input that replaces pixel data with pix_cnt.
module cam_capture_ctrl import cam_pkg::*; #(
    parameter int BYTES_PER_PIX = BYTES_PER_PIX_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int FRM_W         = FRM_W_DEF
) (
    input  logic                       PCLK_cam,
    input  logic                       rst_n,
    input  logic                       VSYNC_cam,
    input  logic                       HREF_cam,
    input  logic [7:0]                 data_cam,
    input  logic                       conf_done,
    output logic                       on_off_cam,
    input  logic                       start_stream,
`ifdef CAM_TEST_PATTERN_EN
    input  logic                       test_pattern,
`endif
    input  logic                       out_ready,
    output logic [8*BYTES_PER_PIX-1:0] pixel,
    output logic                       pixel_valid,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       overflow,
    output logic [CNT_W-1:0]           pix_cnt,
    output logic [CNT_W-1:0]           line_cnt,
    output logic [FRM_W-1:0]           frame_cnt
);
    localparam int PW = 8 * BYTES_PER_PIX;
    cam_state_t       r_state;
    logic             r_vs, r_vs_d, r_href, r_href_d, r_on_off;
    logic [7:0]       r_data;
    logic             r_pv, r_fd, r_fe, r_ovf;
    logic [PW-1:0]    r_pixel;
    logic [CNT_W-1:0] r_pix_cnt, r_line_cnt;
    logic [FRM_W-1:0] r_frame_cnt;
    logic             w_vs_rise, w_vs_fall, w_href_fall, w_active, w_clr, w_en, w_last;
    logic [PW-1:0]    w_word, w_pix_data;
    logic [CNT_W-1:0] w_pix_now;
    assign w_vs_rise   = r_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_vs & r_vs_d;
    assign w_href_fall = ~r_href & r_href_d;
    assign w_active    = r_state == ACTIVE;
    assign w_clr       = (r_state == WAIT_VS && w_vs_fall) || (w_active && w_href_fall);
    assign w_en        = w_active && r_href && !w_vs_rise;
    // pix_cnt advances the cycle after each strobe, so the value seen with pixel_valid is its index
    assign w_pix_now   = (r_pv && !(&r_pix_cnt)) ? r_pix_cnt + CNT_W'(1) : r_pix_cnt;
`ifdef CAM_TEST_PATTERN_EN
    assign w_pix_data  = test_pattern ? PW'(w_pix_now) : w_word;
`else
    assign w_pix_data  = w_word;
`endif
    cam_byte_packer #(.BYTES_PER_PIX(BYTES_PER_PIX)) u_packer (
        .i_clk   (PCLK_cam),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_byte  (r_data),
        .o_last  (w_last),
        .o_word  (w_word)
    );
    always_ff @(posedge PCLK_cam or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vs        <= 1'b0;
            r_vs_d      <= 1'b0;
            r_href      <= 1'b0;
            r_href_d    <= 1'b0;
            r_data      <= '0;
            r_on_off    <= 1'b1;
            r_pv        <= 1'b0;
            r_fd        <= 1'b0;
            r_fe        <= 1'b0;
            r_ovf       <= 1'b0;
            r_pixel     <= '0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_vs      <= VSYNC_cam;
            r_vs_d    <= r_vs;
            r_href    <= HREF_cam;
            r_href_d  <= r_href;
            r_data    <= data_cam;
            r_on_off  <= conf_done ? 1'b0 : r_on_off;
            r_pv      <= 1'b0;
            r_fd      <= 1'b0;
            r_fe      <= 1'b0;
            r_pix_cnt <= w_pix_now;
            case (r_state)
                IDLE: if (start_stream && !r_on_off) begin
                    r_state <= WAIT_VS;
                    r_ovf   <= 1'b0;
                end
                WAIT_VS: if (w_vs_fall) begin
                    r_state    <= ACTIVE;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= '0;
                end
                default: if (w_vs_rise) begin
                    r_fd        <= 1'b1;
                    r_fe        <= r_state == DROP;
                    r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                    r_state     <= start_stream ? WAIT_VS : IDLE;
                end else if (w_active && w_href_fall) begin
                    r_line_cnt <= (&r_line_cnt) ? r_line_cnt : r_line_cnt + CNT_W'(1);
                    r_pix_cnt  <= '0;
                end else if (w_last) begin
                    r_pv    <= out_ready;
                    r_pixel <= out_ready ? w_pix_data : r_pixel;
                    r_ovf   <= r_ovf | !out_ready;
                    r_state <= out_ready ? ACTIVE : DROP;
                end
            endcase
        end
    end
    assign on_off_cam  = r_on_off;
    assign pixel       = r_pixel;
    assign pixel_valid = r_pv;
    assign frame_done  = r_fd;
    assign frame_err   = r_fe;
    assign overflow    = r_ovf;
    assign pix_cnt     = r_pix_cnt;
    assign line_cnt    = r_line_cnt;
    assign frame_cnt   = r_frame_cnt;
endmodule
